// File: rtl/lcd_scanout.sv
// Double-buffered 160x144 2-bit frame store fed by the PPU, scanned out as
// integer-scaled, centred VGA with bank exchange only at VGA frame start.
module lcd_scanout #(
  parameter int          PIX_DIV = 4,
  parameter int          H_ACT   = 640,
  parameter int          H_FP    = 16,
  parameter int          H_SYN   = 96,
  parameter int          H_BP    = 48,
  parameter int          V_ACT   = 480,
  parameter int          V_FP    = 10,
  parameter int          V_SYN   = 2,
  parameter int          V_BP    = 33,
  parameter int          SCALE   = 3,
  parameter int          X_OFF   = 80,
  parameter int          Y_OFF   = 24,
  parameter logic [11:0] BORDER  = 12'h000,
  parameter int          GB_W    = 160,
  parameter int          GB_H    = 144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ppu_pixel,
  input  logic [15:0] ppu_lcd_a,
  input  logic        ppu_lcd_wr,
  input  logic        ppu_vsync,
  input  logic        lcd_on,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_swap
);

  localparam int H_TOT   = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT   = V_ACT + V_FP + V_SYN + V_BP;
  localparam int FB_SIZE = GB_W * GB_H;
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);
  localparam int AW      = $clog2(FB_SIZE + 1);
  localparam int IW      = $clog2(FB_SIZE);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int SC_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int GX_W    = $clog2(GB_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0]    H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0]    HS_BEG   = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0]    HS_END   = HW'(H_ACT + H_FP + H_SYN - 1);
  localparam logic [HW-1:0]    X_BEG    = HW'(X_OFF);
  localparam logic [HW-1:0]    X_END    = HW'(X_OFF + GB_W * SCALE - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0]    V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0]    VS_BEG   = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0]    VS_END   = VW'(V_ACT + V_FP + V_SYN - 1);
  localparam logic [VW-1:0]    Y_BEG    = VW'(Y_OFF);
  localparam logic [VW-1:0]    Y_END    = VW'(Y_OFF + GB_H * SCALE - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCALE - 1);
  localparam logic [GX_W-1:0]  GX_LAST  = GX_W'(GB_W - 1);
  localparam logic [AW-1:0]    ROW_STEP = AW'(GB_W);
  localparam logic [15:0]      FB_LIM   = 16'(FB_SIZE);

  function automatic logic [11:0] palette(input logic [1:0] shade);
    logic [11:0] rgb;
    case (shade)
      2'd0:    rgb = 12'hCEB;
      2'd1:    rgb = 12'h8A6;
      2'd2:    rgb = 12'h354;
      default: rgb = 12'h021;
    endcase
    return rgb;
  endfunction

  function automatic logic [11:0] pixel_rgb(input logic de, input logic win,
                                            input logic on, input logic [1:0] shade);
    logic [11:0] rgb;
    if (!de)              rgb = 12'h000;
    else if (!win || !on) rgb = BORDER;
    else                  rgb = palette(shade);
    return rgb;
  endfunction

  logic [DIV_W-1:0] pix_cnt;
  logic             pix_en;
  logic [HW-1:0]    hcnt;
  logic [VW-1:0]    vcnt;
  logic             h_end, v_end;
  logic             hs_raw, vs_raw, de_raw, win_h, win_v, in_win;
  logic [SC_W-1:0]  sx, sy;
  logic [GX_W-1:0]  gx;
  logic [AW-1:0]    row_base, rd_addr;
  logic [IW-1:0]    rd_idx, wr_idx;
  logic             front, swap_pend, do_swap, wr_ok;
  logic             vsync_p0, vsync_p1, vs_rise;

  logic [1:0]       bank0 [FB_SIZE];
  logic [1:0]       bank1 [FB_SIZE];
  logic [1:0]       rd0_p1, rd1_p1, shade_p1;
  logic             hs_p1, vs_p1, de_p1, win_p1, front_p1;
  logic             hs_p2, vs_p2, de_p2;
  logic [11:0]      rgb_p2;

  assign pix_en = (pix_cnt == DIV_LAST);
  assign h_end  = (hcnt == H_LAST);
  assign v_end  = (vcnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      pix_cnt <= pix_en ? '0 : pix_cnt + 1'b1;
      if (pix_en) begin
        hcnt <= h_end ? '0 : hcnt + 1'b1;
        if (h_end) vcnt <= v_end ? '0 : vcnt + 1'b1;
      end
    end
  end

  assign hs_raw = !((hcnt >= HS_BEG) && (hcnt <= HS_END));
  assign vs_raw = !((vcnt >= VS_BEG) && (vcnt <= VS_END));
  assign de_raw = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign win_h  = (hcnt >= X_BEG) && (hcnt <= X_END);
  assign win_v  = (vcnt >= Y_BEG) && (vcnt <= Y_END);
  assign in_win = win_h && win_v;

  // Scale counters replace a divide: gx/row_base step once per SCALE pixels/lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx       <= '0;
      gx       <= '0;
      sy       <= '0;
      row_base <= '0;
    end else if (pix_en) begin
      if (h_end) begin
        sx <= '0;
        gx <= '0;
        if (v_end) begin
          sy       <= '0;
          row_base <= '0;
        end else if (win_v) begin
          if (sy == SC_LAST) begin
            sy       <= '0;
            row_base <= row_base + ROW_STEP;
          end else begin
            sy <= sy + 1'b1;
          end
        end
      end else if (in_win) begin
        if (sx == SC_LAST) begin
          sx <= '0;
          gx <= (gx == GX_LAST) ? '0 : gx + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

  assign rd_addr = in_win ? (row_base + AW'(gx)) : '0;
  assign rd_idx  = rd_addr[IW-1:0];
  assign wr_idx  = ppu_lcd_a[IW-1:0];
  assign wr_ok   = ppu_lcd_wr && (ppu_lcd_a < FB_LIM);

  // The back bank is always the one front does not select, so the PPU never
  // writes the bank being scanned.
  always_ff @(posedge clk) begin
    if (wr_ok && front)  bank0[wr_idx] <= ppu_pixel;
    if (wr_ok && !front) bank1[wr_idx] <= ppu_pixel;
  end

  assign vs_rise = vsync_p0 && !vsync_p1;
  assign do_swap = pix_en && h_end && v_end && swap_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p0   <= 1'b0;
      vsync_p1   <= 1'b0;
      front      <= 1'b0;
      swap_pend  <= 1'b0;
      frame_swap <= 1'b0;
    end else begin
      vsync_p0   <= ppu_vsync;
      vsync_p1   <= vsync_p0;
      frame_swap <= do_swap;
      if (do_swap) front <= ~front;
      if (vs_rise)      swap_pend <= 1'b1;
      else if (do_swap) swap_pend <= 1'b0;
    end
  end

  // Stage 1: frame buffer read, timing flags delayed alongside
  always_ff @(posedge clk) begin
    if (pix_en) begin
      rd0_p1 <= bank0[rd_idx];
      rd1_p1 <= bank1[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      de_p1    <= 1'b0;
      win_p1   <= 1'b0;
      front_p1 <= 1'b0;
    end else if (pix_en) begin
      hs_p1    <= hs_raw;
      vs_p1    <= vs_raw;
      de_p1    <= de_raw;
      win_p1   <= in_win;
      front_p1 <= front;
    end
  end

  assign shade_p1 = front_p1 ? rd1_p1 : rd0_p1;

  // Stage 2: palette and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      de_p2  <= 1'b0;
      rgb_p2 <= 12'h000;
    end else if (pix_en) begin
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      de_p2  <= de_p1;
      rgb_p2 <= pixel_rgb(de_p1, win_p1, lcd_on, shade_p1);
    end
  end

  assign vga_r  = rgb_p2[11:8];
  assign vga_g  = rgb_p2[7:4];
  assign vga_b  = rgb_p2[3:0];
  assign vga_hs = hs_p2;
  assign vga_vs = vs_p2;
  assign vga_de = de_p2;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: a reduced-geometry instance for frame content/swap
// behaviour plus a default instance for full-size horizontal timing.
module tb_lcd_scanout;

  localparam int PD = 2, HA = 56, HF = 2, HSY = 4, HB = 2;
  localparam int VA = 28, VF = 1, VSY = 2, VB = 1;
  localparam int SC = 3, XO = 4, YO = 2, GW = 16, GH = 8;
  localparam logic [11:0] BORD = 12'h00F;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FB = GW * GH;
  localparam int FRAME_CLK = HT * VT * PD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ppu_pixel = 2'd0;
  logic [15:0] ppu_lcd_a = 16'd0;
  logic        ppu_lcd_wr = 1'b0;
  logic        ppu_vsync = 1'b0;
  logic        lcd_on = 1'b1;
  logic [3:0]  r, g, b, ar, ag, ab;
  logic        hs, vs, de, fswap, ahs, avs, ade, afswap;

  always #5 clk = ~clk;

  lcd_scanout #(
    .PIX_DIV(PD), .H_ACT(HA), .H_FP(HF), .H_SYN(HSY), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYN(VSY), .V_BP(VB),
    .SCALE(SC), .X_OFF(XO), .Y_OFF(YO), .BORDER(BORD), .GB_W(GW), .GB_H(GH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ppu_pixel(ppu_pixel), .ppu_lcd_a(ppu_lcd_a),
    .ppu_lcd_wr(ppu_lcd_wr), .ppu_vsync(ppu_vsync), .lcd_on(lcd_on),
    .vga_r(r), .vga_g(g), .vga_b(b), .vga_hs(hs), .vga_vs(vs), .vga_de(de),
    .frame_swap(fswap)
  );

  lcd_scanout dut_full (
    .clk(clk), .rst_n(rst_n), .ppu_pixel(ppu_pixel), .ppu_lcd_a(ppu_lcd_a),
    .ppu_lcd_wr(ppu_lcd_wr), .ppu_vsync(ppu_vsync), .lcd_on(lcd_on),
    .vga_r(ar), .vga_g(ag), .vga_b(ab), .vga_hs(ahs), .vga_vs(avs), .vga_de(ade),
    .frame_swap(afswap)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [11:0] img [VA][HA*PD];
  logic [1:0]  model [2][FB];
  int          model_front = 0;
  int          xcur = 0, ycur = 0, swap_cnt = 0, de0_bad = 0;
  logic        de_q = 1'b0;
  int          a_fall1 = -1, a_fall2 = -1, a_rise1 = -1;
  int          b_fall1 = -1, b_fall2 = -1, b_rise1 = -1;
  logic        ahs_q = 1'b1, vs_q = 1'b1;

  typedef struct { int x; int y; logic [11:0] exp; } pt_t;
  pt_t t2v [12];
  pt_t t3v [9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!de && ({r, g, b} != 12'h000)) de0_bad++;
    if (fswap) swap_cnt++;
    if (!vs) begin
      ycur = 0;
      xcur = 0;
    end else if (de) begin
      if (ycur < VA && xcur < HA * PD) img[ycur][xcur] = {r, g, b};
      xcur++;
    end else if (de_q) begin
      ycur++;
      xcur = 0;
    end
    de_q = de;
    if (ahs_q && !ahs) begin
      if (a_fall1 < 0) a_fall1 = cyc;
      else if (a_fall2 < 0) a_fall2 = cyc;
    end
    if (!ahs_q && ahs && a_fall1 >= 0 && a_rise1 < 0) a_rise1 = cyc;
    ahs_q = ahs;
    if (vs_q && !vs) begin
      if (b_fall1 < 0) b_fall1 = cyc;
      else if (b_fall2 < 0) b_fall2 = cyc;
    end
    if (!vs_q && vs && b_fall1 >= 0 && b_rise1 < 0) b_rise1 = cyc;
    vs_q = vs;
  end

  function automatic logic [11:0] pal(input logic [1:0] s);
    case (s)
      2'd0:    return 12'hCEB;
      2'd1:    return 12'h8A6;
      2'd2:    return 12'h354;
      default: return 12'h021;
    endcase
  endfunction

  function automatic logic [11:0] exp_px(input int x, input int y, input logic on);
    int gxi, gyi;
    if (!on) return BORD;
    if (x < XO || x >= XO + GW * SC || y < YO || y >= YO + GH * SC) return BORD;
    gxi = (x - XO) / SC;
    gyi = (y - YO) / SC;
    return pal(model[model_front][gyi * GW + gxi]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting, expected event within bound", name);
  endtask

  task automatic wait_vs_fall(input string name);
    bit seen_hi = 0;
    bit ok = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (vs) seen_hi = 1;
      else if (seen_hi) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_swap(input string name);
    int base = swap_cnt;
    bit ok = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (swap_cnt != base) begin ok = 1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic clear_img();
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA * PD; x++) img[y][x] = 12'hBAD;
  endtask

  task automatic write_px(input int a, input logic [1:0] s);
    @(negedge clk);
    ppu_lcd_a  = 16'(a);
    ppu_pixel  = s;
    ppu_lcd_wr = 1'b1;
    if (a < FB) model[1 - model_front][a] = s;
    @(negedge clk);
    ppu_lcd_wr = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk);
    ppu_vsync = 1'b1;
    repeat (3) @(negedge clk);
    ppu_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input logic on);
    int mism = 0;
    string detail = "";
    for (int y = 0; y < VA; y++)
      for (int xs = 0; xs < HA * PD; xs++)
        if (img[y][xs] !== exp_px(xs / PD, y, on)) begin
          if (mism == 0)
            detail = $sformatf("%s first diff y%0d x%0d got %h exp %h", name, y, xs / PD,
                               img[y][xs], exp_px(xs / PD, y, on));
          mism++;
        end
    check(mism == 0 ? name : detail, mism, 0);
  endtask

  task automatic check_table2();
    foreach (t2v[i])
      check($sformatf("T2 px(%0d,%0d)", t2v[i].x, t2v[i].y),
            img[t2v[i].y][t2v[i].x * PD], t2v[i].exp);
  endtask

  task automatic check_table3();
    foreach (t3v[i])
      check($sformatf("T3 px(%0d,%0d)", t3v[i].x, t3v[i].y),
            img[t3v[i].y][t3v[i].x * PD], t3v[i].exp);
  endtask

  initial begin
    int base, n;
    bit ok;
    t2v[0]  = '{4, 2, 12'h021};  t2v[1]  = '{6, 4, 12'h021};  t2v[2]  = '{5, 3, 12'h021};
    t2v[3]  = '{7, 2, 12'h8A6};  t2v[4]  = '{10, 2, 12'h354}; t2v[5]  = '{13, 2, 12'h021};
    t2v[6]  = '{4, 5, 12'hCEB};  t2v[7]  = '{7, 5, 12'h8A6};  t2v[8]  = '{3, 2, 12'h00F};
    t2v[9]  = '{52, 2, 12'h00F}; t2v[10] = '{4, 1, 12'h00F};  t2v[11] = '{4, 26, 12'h00F};
    t3v[0]  = '{49, 23, 12'h354}; t3v[1] = '{51, 25, 12'h354}; t3v[2] = '{50, 24, 12'h354};
    t3v[3]  = '{48, 25, 12'hCEB}; t3v[4] = '{49, 22, 12'hCEB}; t3v[5] = '{4, 2, 12'hCEB};
    t3v[6]  = '{7, 2, 12'hCEB};   t3v[7] = '{52, 25, 12'h00F}; t3v[8] = '{51, 26, 12'h00F};

    repeat (4) @(negedge clk);
    check("reset hs", hs, 1);
    check("reset vs", vs, 1);
    check("reset de", de, 0);
    check("reset rgb", {r, g, b}, 0);
    check("reset frame_swap", fswap, 0);
    rst_n = 1'b1;

    for (int a = 0; a < FB; a++) write_px(a, 2'(a % 4));
    pulse_vsync();
    wait_swap("S1 swap");
    model_front = 1;
    for (int a = 0; a < FB; a++) write_px(a, 2'd0);
    pulse_vsync();
    wait_swap("S2 swap");
    model_front = 0;
    clear_img();

    write_px(0, 2'd3);
    base = swap_cnt;
    pulse_vsync();
    wait_vs_fall("T2 current frame end");
    check_frame("T2 current frame unchanged", 1'b1);
    check("T2 no swap mid-frame", swap_cnt - base, 0);

    wait_swap("S3 swap");
    model_front = 1;
    clear_img();
    base = swap_cnt;
    write_px(127, 2'd2);
    write_px(128, 2'd3);
    write_px(257, 2'd3);
    write_px(23040, 2'd3);
    pulse_vsync();
    pulse_vsync();
    pulse_vsync();
    wait_vs_fall("T2 new frame end");
    check_frame("T2 new frame", 1'b1);
    check_table2();
    check("T4 no swap during frame", swap_cnt - base, 0);

    wait_swap("S4 swap");
    model_front = 0;
    clear_img();
    wait_vs_fall("T3 frame end");
    check_frame("T3 bounds frame", 1'b1);
    check_table3();
    check("T4 single swap", swap_cnt - base, 1);

    lcd_on = 1'b0;
    clear_img();
    wait_vs_fall("T5 frame end");
    check_frame("T5 lcd_on=0 frame", 1'b0);
    check("T4 no further swap", swap_cnt - base, 1);
    lcd_on = 1'b1;

    ok = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (de && {r, g, b} != BORD) begin ok = 1; break; end
    end
    if (!ok) timeout("T6 wait active pixel");
    #2 rst_n = 1'b0;
    #1;
    check("T6 async hs", hs, 1);
    check("T6 async vs", vs, 1);
    check("T6 async de", de, 0);
    check("T6 async rgb", {r, g, b}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (!hs) begin ok = 1; break; end
    end
    if (!ok) timeout("T6 hs after release");
    check("T6 first hs fall after release", n, (HA + HF) * PD + 2 * PD);

    check("T1 full hs period", a_fall2 - a_fall1, 3200);
    check("T1 full hs low", a_rise1 - a_fall1, 384);
    check("T1 vs period", b_fall2 - b_fall1, FRAME_CLK);
    check("T1 vs low", b_rise1 - b_fall1, VSY * HT * PD);
    check("T5 rgb zero when de low", de0_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
